// File: rtl/manchester_pkg.sv
// Shared state encoding, constants and line-level helper for the Manchester transmit path.
package manchester_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      GAP      = 2'd3
   } state_e;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic       MODE_IEEE     = 1'b0;
   localparam logic       MODE_THOMAS   = 1'b1;

   // Phase 0 is the first half of the bit cell.
   function automatic logic manch_half(input logic bit_v, input logic mode, input logic phase);
      logic ieee_level;
      ieee_level = phase ? bit_v : ~bit_v;
      return (mode == MODE_THOMAS) ? ~ieee_level : ieee_level;
   endfunction

endpackage

// File: rtl/manchester_bit_timer.sv
// Half-bit timer: counts CLK_DIV cycles per half-bit, strobes half_tick on the last
// cycle of each half and reports which half of the bit cell is on the line.
module manchester_bit_timer
   import manchester_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic half_tick,
   output logic phase
);

   localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (clr) begin
         cnt_d   = RELOAD;
         phase_d = 1'b0;
      end else if (en) begin
         if (cnt_q == 8'd0) begin
            cnt_d   = RELOAD;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= RELOAD;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign half_tick = en & (cnt_q == 8'd0);
   assign phase     = phase_q;

endmodule

// File: rtl/manchester_tx_sched.sv
// Two-requester round-robin scheduler that frames each byte with 8'h55 preamble bytes and
// serialises it as Manchester half-bits. Define MANCHESTER_PARITY_EN to append an even-parity bit.
module manchester_tx_sched
   import manchester_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int PREAMBLE_LEN = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   input  logic       mode,
   output logic       tx_out,
   output logic       tx_en,
   output logic       busy,
   output logic       grant_id,
   output logic       frame_done
);

   localparam int PRE_BITS = PREAMBLE_LEN * 8;
`ifdef MANCHESTER_PARITY_EN
   localparam int NBITS = PRE_BITS + 9;
`else
   localparam int NBITS = PRE_BITS + 8;
`endif
   localparam int BCW = $clog2((PREAMBLE_LEN + 1) * 8 + 2);

   localparam logic [BCW-1:0] PRE_END  = BCW'(PRE_BITS);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(NBITS - 1);
   localparam logic [BCW-1:0] GAP_LAST = BCW'(1);

   state_e         state_q, state_d;
   logic [BCW-1:0] bit_idx_q, bit_idx_d;
   logic [7:0]     data_q, data_d;
   logic           mode_q, mode_d;
   logic           grant_q, grant_d;
   logic           last_q, last_d;

   logic sel0, sel1, accept;
   logic half_tick, phase, bit_end;
   logic cur_bit, active, timer_en;

   assign timer_en = (state_q != IDLE);

   manchester_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr       (accept),
      .en        (timer_en),
      .half_tick (half_tick),
      .phase     (phase)
   );

   assign bit_end = half_tick & phase;

   // last_q holds the most recent winner; on a tie the other requester goes next.
   always_comb begin
      sel0       = req0_valid & (~req1_valid | last_q);
      sel1       = req1_valid & (~req0_valid | ~last_q);
      req0_ready = (state_q == IDLE) & sel0;
      req1_ready = (state_q == IDLE) & sel1;
      accept     = req0_ready | req1_ready;
   end

   // Preamble and data both start on a byte boundary, so the low index bits pick the bit.
   always_comb begin
      cur_bit = data_q[3'd7 - bit_idx_q[2:0]];
      if (state_q == PREAMBLE) begin
         cur_bit = PREAMBLE_BYTE[3'd7 - bit_idx_q[2:0]];
      end
`ifdef MANCHESTER_PARITY_EN
      else if (bit_idx_q == LAST_BIT) begin
         cur_bit = ^data_q;
      end
`endif
   end

   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      data_d     = data_q;
      mode_d     = mode_q;
      grant_d    = grant_q;
      last_d     = last_q;
      frame_done = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = (PREAMBLE_LEN == 0) ? DATA : PREAMBLE;
               bit_idx_d = '0;
               data_d    = req1_ready ? req1_data : req0_data;
               mode_d    = mode;
               grant_d   = req1_ready;
               last_d    = req1_ready;
            end
         end
         PREAMBLE: begin
            if (bit_end) begin
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_d == PRE_END) state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx_q == LAST_BIT) begin
                  state_d    = GAP;
                  bit_idx_d  = '0;
                  frame_done = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         GAP: begin
            // The gap is timed as two idle bit cells on the same half-bit timer.
            if (bit_end) begin
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == GAP_LAST) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_idx_q <= '0;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
      mode_q <= mode_d;
   end

   assign active   = (state_q == PREAMBLE) | (state_q == DATA);
   assign tx_en    = active;
   assign tx_out   = active & manch_half(cur_bit, mode_q, phase);
   assign busy     = (state_q != IDLE);
   assign grant_id = grant_q;

endmodule

// File: tb/tb_manchester_tx_sched.sv
// Randomised scoreboard bench for manchester_tx_sched with a frame-level reference model.
module tb_manchester_tx_sched;

   localparam int CLK_DIV      = 4;
   localparam int PREAMBLE_LEN = 2;
`ifdef MANCHESTER_PARITY_EN
   localparam int NB = PREAMBLE_LEN * 8 + 9;
`else
   localparam int NB = PREAMBLE_LEN * 8 + 8;
`endif
   localparam int FLEN    = NB * 2 * CLK_DIV;
   localparam int GLEN    = 2 * 2 * CLK_DIV;
   localparam int SPACING = FLEN + GLEN + 1;
   localparam int RST_AT  = PREAMBLE_LEN * 8 * 2 * CLK_DIV + 22;

   logic       clk, rst;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0] req0_data, req1_data;
   logic       mode, mode_fixed, wiggle, wig_val;
   logic       tx_out, tx_en, busy, grant_id, frame_done;

   typedef struct {
      bit         id;
      logic [7:0] data;
      logic       mode;
   } txn_t;

   txn_t sb_q[$];
   bit   hs_ids[$];
   int   nchecks, nerrors, cyc, last_hs, frames_done;
   bit   have_hs, spacing_chk;

   int   fcyc, gcyc, wave_err, fd_err, gap_err;
   bit   start_next, model_last, idle_m, e0, e1;
   txn_t cur;

   manchester_tx_sched #(.CLK_DIV(CLK_DIV), .PREAMBLE_LEN(PREAMBLE_LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .mode       (mode),
      .tx_out     (tx_out),
      .tx_en      (tx_en),
      .busy       (busy),
      .grant_id   (grant_id),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mode = wiggle ? wig_val : mode_fixed;
   initial begin
      wig_val = 1'b0;
      forever begin
         @(posedge clk);
         #1 wig_val = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Frame content: PREAMBLE_LEN bytes of 8'h55, the data byte MSB first, then optional parity.
   function automatic logic model_bit(input txn_t t, input int b);
      logic [7:0] p;
      int pb;
      p  = 8'h55;
      pb = PREAMBLE_LEN * 8;
      if (b < pb)     return p[7 - (b % 8)];
      if (b < pb + 8) return t.data[7 - (b - pb)];
      return ^t.data;
   endfunction

   // IEEE: 1 -> low,high and 0 -> high,low; Thomas is the opposite pairing.
   function automatic logic model_level(input txn_t t, input int c);
      int   h;
      logic bv;
      bit   second;
      h      = (c - 1) / CLK_DIV;
      bv     = model_bit(t, h / 2);
      second = (h % 2) == 1;
      if (t.mode == 1'b0) return second ? bv : ~bv;
      return second ? ~bv : bv;
   endfunction

   function automatic void note_hs(input bit id, input logic [7:0] d, input logic m);
      txn_t t;
      t.id = id; t.data = d; t.mode = m;
      sb_q.push_back(t);
      hs_ids.push_back(id);
      if (spacing_chk && have_hs) check("hs_spacing", cyc - last_hs, SPACING);
      last_hs = cyc;
      have_hs = 1'b1;
   endfunction

   task automatic set_req(input bit id, input logic v, input logic [7:0] d);
      if (id) begin req1_valid = v; req1_data = d; end
      else    begin req0_valid = v; req0_data = d; end
   endtask

   task automatic stream(input bit id, input int n, input logic [7:0] b0, input logic [7:0] b1);
      for (int k = 0; k < n; k++) begin
         logic [7:0] d;
         bit ok;
         d  = (k == 0) ? b0 : (k == 1) ? b1 : 8'($urandom);
         ok = 1'b0;
         set_req(id, 1'b1, d);
         for (int w = 0; w < 4000 && !ok; w++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
               note_hs(id, d, mode);
               ok = 1'b1;
            end
         end
         if (!ok) begin
            check("hs_timeout", 0, 1);
            set_req(id, 1'b0, 8'h00);
            return;
         end
         @(posedge clk);
         #1;
      end
      set_req(id, 1'b0, 8'h00);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int w = 0; w < 3000 && !done; w++) begin
         @(negedge clk);
         if (busy === 1'b0 && sb_q.size() == 0 && fcyc == 0 && gcyc == 0 && !start_next) done = 1'b1;
      end
      if (!done) check("idle_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      set_req(0, 1'b0, 8'h00);
      set_req(1, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      have_hs = 1'b0;
      hs_ids.delete();
   endtask

   // Monitor: tracks frame/gap timing from handshakes and compares every cycle.
   initial begin
      fcyc = 0; gcyc = 0; start_next = 1'b0; model_last = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            fcyc = 0; gcyc = 0; start_next = 1'b0; model_last = 1'b1;
         end else begin
            idle_m = (fcyc == 0 && gcyc == 0 && !start_next);
            if (start_next) begin
               start_next = 1'b0;
               if (sb_q.size() == 0) check("sb_underflow", 0, 1);
               else cur = sb_q.pop_front();
               check("grant_id", grant_id, cur.id);
               fcyc = 1; wave_err = 0; fd_err = 0;
            end
            if (fcyc > 0) begin
               if (tx_en !== 1'b1 || tx_out !== model_level(cur, fcyc)) wave_err++;
               if (frame_done !== (fcyc == FLEN)) fd_err++;
               if (fcyc == FLEN) begin
                  check("waveform_bad_cycles", wave_err, 0);
                  check("frame_done_pos", fd_err, 0);
                  frames_done++;
                  fcyc = 0; gcyc = 1; gap_err = 0;
               end else begin
                  fcyc++;
               end
            end else if (gcyc > 0) begin
               if (tx_en !== 1'b0 || tx_out !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) gap_err++;
               if (gcyc == GLEN) begin
                  check("gap_bad_cycles", gap_err, 0);
                  gcyc = 0;
               end else begin
                  gcyc++;
               end
            end else if (idle_m) begin
               check("idle_outputs", {tx_en, tx_out, busy, frame_done}, 4'b0000);
            end
            e0 = idle_m && req0_valid && (!req1_valid || model_last);
            e1 = idle_m && req1_valid && (!req0_valid || !model_last);
            if (idle_m || req0_ready || req1_ready) check("ready_pair", {req0_ready, req1_ready}, {e0, e1});
            if (e0 || e1) begin
               model_last = e1;
               start_next = 1'b1;
            end
         end
      end
   end

   initial begin
      int t0, fd0;
      nchecks = 0; nerrors = 0; cyc = 0; frames_done = 0;
      have_hs = 1'b0; spacing_chk = 1'b0; wiggle = 1'b0; mode_fixed = 1'b0;
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {tx_out, tx_en, busy, grant_id, frame_done}, 5'b00000);
      check("rst_readies", {req0_ready, req1_ready}, 2'b00);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single IEEE request
      mode_fixed = 1'b0;
      t0 = cyc;
      stream(0, 1, 8'hB2, 8'h00);
      check("first_valid_accept", last_hs - t0, 0);
      check("tx_en_after_hs", tx_en, 1'b1);
      wait_idle();

      // Thomas mode with mode toggling during the frame
      mode_fixed = 1'b1;
      stream(1, 1, 8'hF0, 8'h00);
      wiggle = 1'b1;
      wait_idle();
      wiggle = 1'b0;
      check("grant_id_holds", grant_id, 1'b1);

      // Contention from reset
      mode_fixed = 1'b0;
      do_reset();
      spacing_chk = 1'b1;
      fork
         stream(0, 2, 8'h0F, 8'h07);
         stream(1, 1, 8'hF0, 8'h00);
      join
      wait_idle();
      check("contend_count", hs_ids.size(), 3);
      for (int k = 0; k < hs_ids.size(); k++) check("contend_order", hs_ids[k], k % 2);

      // Back-to-back on one requester
      have_hs = 1'b0;
      stream(0, 3, 8'($urandom), 8'($urandom));
      wait_idle();
      spacing_chk = 1'b0;

      // Randomised traffic
      wiggle = 1'b1;
      for (int i = 0; i < 12; i++) begin
         int c;
         c = $urandom_range(0, 2);
         repeat ($urandom_range(0, 40)) @(posedge clk);
         #1;
         case (c)
            0: stream(0, 1, 8'($urandom), 8'h00);
            1: stream(1, 1, 8'($urandom), 8'h00);
            default: fork
               stream(0, 1, 8'($urandom), 8'h00);
               stream(1, 1, 8'($urandom), 8'h00);
            join
         endcase
         if (i == 3) begin
            set_req(1, 1'b1, 8'hAA);
            repeat (5) @(posedge clk);
            #1 set_req(1, 1'b0, 8'h00);
         end
      end
      wait_idle();
      wiggle = 1'b0;

      // Reset in the data section of a req0 frame
      mode_fixed = 1'($urandom_range(0, 1));
      stream(0, 1, 8'($urandom), 8'h00);
      fd0 = frames_done;
      repeat (RST_AT - 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_outputs", {tx_en, tx_out, busy, frame_done, grant_id}, 5'b00000);
      hs_ids.delete();
      have_hs = 1'b0;
      fork
         stream(0, 1, 8'($urandom), 8'h00);
         stream(1, 1, 8'($urandom), 8'h00);
      join
      wait_idle();
      check("midrst_hs_count", hs_ids.size(), 2);
      if (hs_ids.size() > 0) check("midrst_first_grant", hs_ids[0], 0);
      check("midrst_frames", frames_done - fd0, 2);

      repeat (5) @(posedge clk);
      check("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
